// File: rtl/mlops_pkg.sv
// Shared types for the ML-ops datapath blocks: activation modes, chunk FSM states
// and a chunk-count helper.
package mlops_pkg;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    RELU  = 2'd1,
    LEAKY = 2'd2,
    CLIP  = 2'd3
  } act_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } act_state_t;

  function automatic int num_chunks(input int len, input int regs);
    return (len + regs - 1) / regs;
  endfunction

endpackage

// File: rtl/v_act_lane.sv
// Single-lane combinational activation (pass / ReLU / leaky ReLU / clip).
// Clip is only built when V_ACTIVATION_CLIP_EN is defined; otherwise CLIP acts as ReLU.
module v_act_lane
  import mlops_pkg::*;
#(
  parameter int NBits     = 8,
  parameter int LeakShift = 7
`ifdef V_ACTIVATION_CLIP_EN
  ,
  parameter int ClipMax   = 127
`endif
) (
  input  logic signed [NBits-1:0] x,
  input  act_mode_t               mode,
  output logic signed [NBits-1:0] y
);

  logic                    neg;
  logic signed [NBits-1:0] relu_y;
  logic signed [NBits-1:0] leaky_y;
  logic signed [NBits-1:0] clip_y;

  assign neg     = x[NBits-1];
  assign relu_y  = neg ? '0 : x;
  assign leaky_y = neg ? (x >>> LeakShift) : x;

`ifdef V_ACTIVATION_CLIP_EN
  localparam logic signed [NBits-1:0] ClipVal = NBits'(ClipMax);
  assign clip_y = neg ? '0 : ((x > ClipVal) ? ClipVal : x);
`else
  assign clip_y = relu_y;
`endif

  always_comb begin
    y = x;
    case (mode)
      PASS:    y = x;
      RELU:    y = relu_y;
      LEAKY:   y = leaky_y;
      CLIP:    y = clip_y;
      default: y = x;
    endcase
  end

endmodule

// File: rtl/v_activation.sv
// Chunked vector activation: pops WorkingRegs-lane chunks from upstream, applies the
// per-vector latched mode and pushes registered results. Optional macro: V_ACTIVATION_CLIP_EN.
module v_activation
  import mlops_pkg::*;
#(
  parameter int InVecLength = 64,
  parameter int WorkingRegs = 8,
  parameter int NBits       = 8,
  parameter int LeakShift   = 7,
  parameter int ClipMax     = 127
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [1:0]                          mode_in,
  input  logic                                in_data_ready,
  input  logic [WorkingRegs-1:0][NBits-1:0]   in_data,
  output logic                                req_chunk_in,
  input  logic                                out_ready_in,
  output logic [WorkingRegs-1:0][NBits-1:0]   write_out_data,
  output logic                                req_chunk_out,
  output logic                                out_vector_valid,
  output logic                                busy,
  output act_state_t                          state_dbg
);

  // Handshake: a chunk moves upstream->here in any cycle where req_chunk_in is 1,
  // and here->downstream in any cycle where req_chunk_out and out_ready_in are both 1.

  localparam int NumChunks = num_chunks(InVecLength, WorkingRegs);
  localparam int CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int LastLanes = InVecLength - (NumChunks - 1) * WorkingRegs;

  if (InVecLength < 1) begin : g_chk_len
    $error("InVecLength must be >= 1");
  end
  if (WorkingRegs < 1) begin : g_chk_regs
    $error("WorkingRegs must be >= 1");
  end
  if (NBits < 2) begin : g_chk_nbits
    $error("NBits must be >= 2");
  end
  if (LeakShift < 0 || LeakShift >= NBits) begin : g_chk_leak
    $error("LeakShift must be in 0..NBits-1");
  end
  if (ClipMax < 1) begin : g_chk_clip
    $error("ClipMax must be positive");
  end

  act_state_t                       state;
  act_state_t                       state_nxt;
  logic [CntW-1:0]                  chunk_cnt;
  act_mode_t                        mode_q;
  act_mode_t                        mode_eff;
  logic                             consume;
  logic                             is_first;
  logic                             is_last;
  logic [WorkingRegs-1:0][NBits-1:0] lane_y;
  logic [WorkingRegs-1:0][NBits-1:0] chunk_res;

  assign req_chunk_in = ~rst_in & in_data_ready & (~req_chunk_out | out_ready_in);
  assign consume      = req_chunk_in;
  assign is_first     = (chunk_cnt == '0);
  assign is_last      = (chunk_cnt == CntW'(NumChunks - 1));

  // Chunk 0 uses mode_in directly so the whole vector sees the mode sampled at its start.
  assign mode_eff = is_first ? act_mode_t'(mode_in) : mode_q;

  for (genvar i = 0; i < WorkingRegs; i++) begin : g_lane
    v_act_lane #(
      .NBits    (NBits),
      .LeakShift(LeakShift)
`ifdef V_ACTIVATION_CLIP_EN
      ,
      .ClipMax  (ClipMax)
`endif
    ) u_lane (
      .x   (in_data[i]),
      .mode(mode_eff),
      .y   (lane_y[i])
    );

    if (i >= LastLanes) begin : g_pad
      assign chunk_res[i] = is_last ? '0 : lane_y[i];
    end else begin : g_live
      assign chunk_res[i] = lane_y[i];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (consume && !is_last) state_nxt = RUN;
      RUN:     if (consume && is_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      chunk_cnt        <= '0;
      mode_q           <= PASS;
      write_out_data   <= '0;
      req_chunk_out    <= 1'b0;
      out_vector_valid <= 1'b0;
    end else if (consume) begin
      write_out_data   <= chunk_res;
      req_chunk_out    <= 1'b1;
      out_vector_valid <= is_last;
      chunk_cnt        <= is_last ? '0 : chunk_cnt + 1'b1;
      if (is_first) begin
        mode_q <= act_mode_t'(mode_in);
      end
    end else if (out_ready_in) begin
      req_chunk_out    <= 1'b0;
      out_vector_valid <= 1'b0;
    end
  end

  assign busy      = (state == RUN);
  assign state_dbg = state;

endmodule

// File: tb/tb_v_activation.sv
// Bench for v_activation: two instances (16/8 with ClipMax=6, and 10/4), vector tables,
// backpressure and reset sequences, checked through per-instance expected queues.
`timescale 1ns/1ps
module tb_v_activation;
  import mlops_pkg::*;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  logic rst_in;

  int total;
  int bad;

  // instance A: 16 elements, 8 lanes
  logic [1:0]      a_mode;
  logic            a_valid;
  logic [7:0][7:0] a_din;
  logic            a_req_in;
  logic            a_out_ready;
  logic [7:0][7:0] a_wdata;
  logic            a_req_out;
  logic            a_ovv;
  logic            a_busy;
  act_state_t      a_state;

  // instance B: 10 elements, 4 lanes
  logic [1:0]      b_mode;
  logic            b_valid;
  logic [3:0][7:0] b_din;
  logic            b_req_in;
  logic            b_out_ready;
  logic [3:0][7:0] b_wdata;
  logic            b_req_out;
  logic            b_ovv;
  logic            b_busy;
  act_state_t      b_state;

  logic [64:0] a_q[$];
  logic [32:0] b_q[$];
  logic [64:0] a_e;
  logic [32:0] b_e;

  v_activation #(
    .InVecLength(16), .WorkingRegs(8), .NBits(8), .LeakShift(7), .ClipMax(6)
  ) u_dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .mode_in(a_mode), .in_data_ready(a_valid),
    .in_data(a_din), .req_chunk_in(a_req_in), .out_ready_in(a_out_ready),
    .write_out_data(a_wdata), .req_chunk_out(a_req_out), .out_vector_valid(a_ovv),
    .busy(a_busy), .state_dbg(a_state)
  );

  v_activation #(
    .InVecLength(10), .WorkingRegs(4), .NBits(8), .LeakShift(7), .ClipMax(127)
  ) u_dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .mode_in(b_mode), .in_data_ready(b_valid),
    .in_data(b_din), .req_chunk_in(b_req_in), .out_ready_in(b_out_ready),
    .write_out_data(b_wdata), .req_chunk_out(b_req_out), .out_vector_valid(b_ovv),
    .busy(b_busy), .state_dbg(b_state)
  );

  function automatic logic [63:0] p8(input int v0, input int v1, input int v2, input int v3,
                                     input int v4, input int v5, input int v6, input int v7);
    logic [7:0][7:0] r;
    r[0] = v0[7:0]; r[1] = v1[7:0]; r[2] = v2[7:0]; r[3] = v3[7:0];
    r[4] = v4[7:0]; r[5] = v5[7:0]; r[6] = v6[7:0]; r[7] = v7[7:0];
    return r;
  endfunction

  function automatic logic [31:0] p4(input int v0, input int v1, input int v2, input int v3);
    logic [3:0][7:0] r;
    r[0] = v0[7:0]; r[1] = v1[7:0]; r[2] = v2[7:0]; r[3] = v3[7:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic a_send(input logic [63:0] d, input logic [1:0] m, input logic [64:0] e,
                        output int waited);
    int n;
    n = 0;
    @(negedge clk_in);
    a_din = d; a_mode = m; a_valid = 1'b1;
    #1;
    while (!a_req_in && n < 50) begin
      @(negedge clk_in); #1; n++;
    end
    waited = n;
    if (!a_req_in) begin
      total++; bad++;
      $display("FAIL a_send_timeout actual=no_pop required=pop");
      a_valid = 1'b0;
    end else begin
      a_q.push_back(e);
      @(posedge clk_in);
    end
  endtask

  task automatic b_send(input logic [31:0] d, input logic [1:0] m, input logic [32:0] e);
    int n;
    n = 0;
    @(negedge clk_in);
    b_din = d; b_mode = m; b_valid = 1'b1;
    #1;
    while (!b_req_in && n < 50) begin
      @(negedge clk_in); #1; n++;
    end
    if (!b_req_in) begin
      total++; bad++;
      $display("FAIL b_send_timeout actual=no_pop required=pop");
      b_valid = 1'b0;
    end else begin
      b_q.push_back(e);
      @(posedge clk_in);
    end
  endtask

  // Output monitors: a transfer happens on the next rising edge when push and ready are high.
  always @(negedge clk_in) begin
    #2;
    if (a_req_out && a_out_ready) begin
      if (a_q.size() == 0) begin
        total++; bad++;
        $display("FAIL a_sb_extra actual=%h required=no_output", {a_ovv, a_wdata});
      end else begin
        a_e = a_q.pop_front();
        chk("a_chunk", {a_ovv, a_wdata}, a_e);
      end
    end
    if (b_req_out && b_out_ready) begin
      if (b_q.size() == 0) begin
        total++; bad++;
        $display("FAIL b_sb_extra actual=%h required=no_output", {b_ovv, b_wdata});
      end else begin
        b_e = b_q.pop_front();
        chk("b_chunk", {b_ovv, b_wdata}, b_e);
      end
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] din;
    logic [64:0] exp;
  } vec_a_t;

  vec_a_t tab[8];

  initial begin
    int w;
    int stall_total;
    int n;
    total = 0; bad = 0;
    rst_in = 1'b1;
    a_valid = 1'b0; a_din = '0; a_mode = 2'd0; a_out_ready = 1'b1;
    b_valid = 1'b0; b_din = '0; b_mode = 2'd0; b_out_ready = 1'b1;

    tab[0] = '{2'd1, p8(-3, -2, -1, 0, 1, 2, 3, 4),  {1'b0, p8(0, 0, 0, 0, 1, 2, 3, 4)}};
    tab[1] = '{2'd1, p8(5, 6, 7, 8, 9, 10, 11, 12),  {1'b1, p8(5, 6, 7, 8, 9, 10, 11, 12)}};
    tab[2] = '{2'd2, p8(-128, -1, 5, -64, 127, 0, -2, 64), {1'b0, p8(-1, -1, 5, -1, 127, 0, -1, 64)}};
    tab[3] = '{2'd0, p8(-128, -1, 5, 0, 0, 0, 0, 0), {1'b1, p8(-1, -1, 5, 0, 0, 0, 0, 0)}};
`ifdef V_ACTIVATION_CLIP_EN
    tab[4] = '{2'd3, p8(-2, 3, 6, 100, -128, 127, 1, 0), {1'b0, p8(0, 3, 6, 6, 0, 6, 1, 0)}};
    tab[5] = '{2'd1, p8(7, 5, -5, 6, 0, 0, 0, 0),    {1'b1, p8(6, 5, 0, 6, 0, 0, 0, 0)}};
`else
    tab[4] = '{2'd3, p8(-2, 3, 6, 100, -128, 127, 1, 0), {1'b0, p8(0, 3, 6, 100, 0, 127, 1, 0)}};
    tab[5] = '{2'd1, p8(7, 5, -5, 6, 0, 0, 0, 0),    {1'b1, p8(7, 5, 0, 6, 0, 0, 0, 0)}};
`endif
    tab[6] = '{2'd0, p8(-3, -128, 127, 1, 2, 3, 4, 5), {1'b0, p8(-3, -128, 127, 1, 2, 3, 4, 5)}};
    tab[7] = '{2'd2, p8(-1, -2, 9, 8, 7, 6, 5, -4),  {1'b1, p8(-1, -2, 9, 8, 7, 6, 5, -4)}};

    // reset state, with upstream offering data while reset is held
    repeat (2) @(negedge clk_in);
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("rst_a_wdata", a_wdata, 64'd0);
    chk("rst_a_req_out", a_req_out, 1'b0);
    chk("rst_a_ovv", a_ovv, 1'b0);
    chk("rst_a_busy", a_busy, 1'b0);
    chk("rst_a_req_in", a_req_in, 1'b0);
    chk("rst_a_state", a_state, IDLE);
    chk("rst_b_req_in", b_req_in, 1'b0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;

    // back-to-back vectors on A
    stall_total = 0;
    for (int i = 0; i < 8; i++) begin
      a_send(tab[i].din, tab[i].mode, tab[i].exp, w);
      stall_total += w;
      if (i == 0) begin
        #1;
        chk("a_busy_after_c0", a_busy, 1'b1);
        chk("a_state_after_c0", a_state, RUN);
      end
    end
    @(negedge clk_in);
    a_valid = 1'b0;
    #1;
    chk("a_throughput_stalls", stall_total, 0);
    chk("a_busy_after_vec", a_busy, 1'b0);

    // backpressure: downstream stalls 3 cycles while a result is pending
    @(negedge clk_in);
    a_out_ready = 1'b0;
    a_din = p8(1, 2, 3, 4, 5, 6, 7, 8); a_mode = 2'd1; a_valid = 1'b1;
    #1;
    chk("bp_first_take", a_req_in, 1'b1);
    a_q.push_back({1'b0, p8(1, 2, 3, 4, 5, 6, 7, 8)});
    @(negedge clk_in);
    a_din = p8(-1, 9, 10, 11, 12, 13, 14, 15);
    #1;
    chk("bp_req_out", a_req_out, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_req_in_low", a_req_in, 1'b0);
      chk("bp_hold_data", a_wdata, p8(1, 2, 3, 4, 5, 6, 7, 8));
      chk("bp_hold_push", a_req_out, 1'b1);
      chk("bp_hold_ovv", a_ovv, 1'b0);
      @(negedge clk_in); #1;
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp_resume", a_req_in, 1'b1);
    a_q.push_back({1'b1, p8(0, 9, 10, 11, 12, 13, 14, 15)});
    @(posedge clk_in);
    @(negedge clk_in);
    a_valid = 1'b0;

    // B: 10 elements in 3 chunks, padding lanes zeroed
    b_send(p4(1, 2, 3, 4), 2'd0, {1'b0, p4(1, 2, 3, 4)});
    #1;
    chk("b_busy_after_c0", b_busy, 1'b1);
    b_send(p4(5, 6, 7, 8), 2'd0, {1'b0, p4(5, 6, 7, 8)});
    b_send(p4(9, 10, 11, 12), 2'd0, {1'b1, p4(9, 10, 0, 0)});
    #1;
    chk("b_busy_after_vec", b_busy, 1'b0);
    @(negedge clk_in);
    b_valid = 1'b0;

    // B: reset after chunk 1 of 3
    b_send(p4(-5, 1, -1, 2), 2'd1, {1'b0, p4(0, 1, 0, 2)});
    b_send(p4(-7, 3, 4, 5), 2'd0, {1'b0, p4(0, 3, 4, 5)});
    #1;
    rst_in = 1'b1;
    #1;
    chk("arst_b_wdata", b_wdata, 32'd0);
    chk("arst_b_req_out", b_req_out, 1'b0);
    chk("arst_b_ovv", b_ovv, 1'b0);
    chk("arst_b_busy", b_busy, 1'b0);
    chk("arst_b_req_in", b_req_in, 1'b0);
    chk("arst_b_state", b_state, IDLE);
    @(negedge clk_in);
    b_valid = 1'b0;
    b_q.delete();
    rst_in = 1'b0;

    b_send(p4(-128, -1, 3, -4), 2'd2, {1'b0, p4(-1, -1, 3, -1)});
    b_send(p4(-2, 0, 0, 1), 2'd0, {1'b0, p4(-1, 0, 0, 1)});
    b_send(p4(7, -8, 5, 5), 2'd1, {1'b1, p4(7, -1, 0, 0)});
    @(negedge clk_in);
    b_valid = 1'b0;

    n = 0;
    while ((a_q.size() != 0 || b_q.size() != 0) && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    #3;
    chk("a_sb_drained", a_q.size(), 0);
    chk("b_sb_drained", b_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
